// File: rtl/shift_add_mult_if.sv
// Start/done handshake bundle for the sequential shift-add multiplier.
// The controller drives the request side; the multiplier returns status and product.
interface shift_add_mult_if #(
   parameter int N = 4
);
   logic           START;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           BUSY;
   logic           DONE;
   logic [2*N-1:0] PRODUCT;

   modport master (
      output START, A, B,
      input  BUSY, DONE, PRODUCT
   );

   modport slave (
      input  START, A, B,
      output BUSY, DONE, PRODUCT
   );
endinterface

// File: rtl/shift_add_mult.sv
// Unsigned N x N shift-add multiplier around a combinational N-bit adder.
// One multiply at a time: N RUN cycles, then a FIN cycle that publishes the product.
module adder_N #(
   parameter int N = 4
) (
   input  logic [N-1:0] P,
   input  logic [N-1:0] Q,
   input  logic         Cin,
   output logic [N-1:0] SUM,
   output logic         Cout
);
   assign {Cout, SUM} = {1'b0, P} + {1'b0, Q} + {{N{1'b0}}, Cin};
endmodule

module shift_add_mult #(
   parameter int N = 4
) (
   input  logic              CLK,
   input  logic              N_RESET,
   shift_add_mult_if.slave   bus
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   m_q, m_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] prod_q, prod_d;
   logic           done_q, done_d;

   logic [N-1:0]   sum;
   logic           cout;
   logic           c;
   logic [N-1:0]   hi_add;

   adder_N #(.N(N)) u_add (
      .P    (hi_q),
      .Q    (m_q),
      .Cin  (1'b0),
      .SUM  (sum),
      .Cout (cout)
   );

   // carry of the add becomes the new MSB of HI after the shift
   assign {c, hi_add} = lo_q[0] ? {cout, sum} : {1'b0, hi_q};

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.START) begin
               m_d     = bus.A;
               hi_d    = '0;
               lo_d    = bus.B;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            {hi_d, lo_d} = {c, hi_add, lo_q[N-1:1]};
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            prod_d  = {hi_q, lo_q};
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state_q <= IDLE;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   assign bus.BUSY    = (state_q == RUN);
   assign bus.DONE    = done_q;
   assign bus.PRODUCT = prod_q;
endmodule
